goertzel_bank: RTL and testbench

Multi-bin streaming Goertzel DFT engine. It is the parametrised successor of the single-bin Goertzel block. It runs NBIN second-order recursions in parallel over frames of N = 2^LGN samples and takes per-bin cos/sin coefficients as inputs, so no internal CORDIC is used. At each frame end it snapshots the bin states. It then drains complex results one bin per handshake, alongside the DSP filter datapath.

---
 rtl/goertzel_bank.sv | 167 ++++++++++++++++
 tb/tb_goertzel_bank.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_bank.sv
// goertzel_bank: NBIN parallel Goertzel recursions over 2^LGN-sample frames,
// snapshotted at frame end and drained one complex bin per handshake.
module goertzel_bank #(
  parameter int SW   = 12,
  parameter int LGN  = 4,
  parameter int NBIN = 4,
  parameter int CFW  = 16,
  parameter int OW   = 32
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  input  logic signed [SW-1:0]                 i_sample,
  input  logic [NBIN*CFW-1:0]                  i_cos,
  input  logic [NBIN*CFW-1:0]                  i_sin,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [((NBIN>1)?$clog2(NBIN):1)-1:0] o_bin,
  output logic signed [OW-1:0]                 o_re,
  output logic signed [OW-1:0]                 o_im,
  output logic                                 o_busy,
  output logic                                 o_overrun
);
  localparam int N  = 1 << LGN;
  localparam int AW = SW + 2*LGN + 2;
  localparam int PW = AW + CFW + 1;
  localparam int BW = (NBIN > 1) ? $clog2(NBIN) : 1;
  localparam int SH = CFW - 2;

  logic [LGN-1:0]        r_cnt;
  logic signed [AW-1:0]  r_s1   [NBIN];
  logic signed [AW-1:0]  r_s2   [NBIN];
  logic signed [CFW-1:0] r_cos  [NBIN];
  logic signed [CFW-1:0] r_sin  [NBIN];
  logic signed [AW-1:0]  r_S1   [NBIN];
  logic signed [AW-1:0]  r_S2   [NBIN];
  logic signed [CFW-1:0] r_scos [NBIN];
  logic signed [CFW-1:0] r_ssin [NBIN];

  logic signed [CFW-1:0] w_fcos [NBIN];
  logic signed [CFW-1:0] w_fsin [NBIN];
  logic signed [AW-1:0]  w_s1e  [NBIN];
  logic signed [AW-1:0]  w_s2e  [NBIN];
  logic signed [PW-1:0]  w_prod [NBIN];
  logic signed [AW-1:0]  w_snew [NBIN];

  logic                  w_first;
  logic                  w_last;
  logic                  w_fend;
  logic                  w_xfer;
  logic                  w_lastx;
  logic                  w_snap;
  logic [BW-1:0]         w_nbin;

  logic signed [AW-1:0]  w_ms1;
  logic signed [AW-1:0]  w_ms2;
  logic signed [CFW-1:0] w_mc;
  logic signed [CFW-1:0] w_ms;
  logic signed [PW-1:0]  w_mre;
  logic signed [PW-1:0]  w_mim;
  logic signed [PW-1:0]  w_re;
  logic signed [PW-1:0]  w_im;

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LGN'(N-1));
  assign w_fend  = i_valid & w_last;
  assign w_xfer  = o_valid & i_ready;
  assign w_lastx = w_xfer & (o_bin == BW'(NBIN-1));
  assign w_snap  = w_fend & (~o_busy | w_lastx);
  assign w_nbin  = w_lastx ? '0 : o_bin + BW'(1);

  // First sample of a frame sees zero history and the live coefficients
  always_comb begin
    for (int b = 0; b < NBIN; b++) begin
      w_fcos[b] = w_first ? $signed(i_cos[b*CFW +: CFW]) : r_cos[b];
      w_fsin[b] = w_first ? $signed(i_sin[b*CFW +: CFW]) : r_sin[b];
      w_s1e[b]  = w_first ? '0 : r_s1[b];
      w_s2e[b]  = w_first ? '0 : r_s2[b];
      w_prod[b] = PW'(w_fcos[b]) * PW'(w_s1e[b]);
      w_snew[b] = AW'(PW'(i_sample)
                + ((w_prod[b] <<< 1) >>> SH)
                - PW'(w_s2e[b]));
    end
  end

  // Shared output multipliers: bin 0 of a fresh snapshot, else next bin
  always_comb begin
    if (w_snap) begin
      w_ms1 = w_snew[0];
      w_ms2 = w_s1e[0];
      w_mc  = w_fcos[0];
      w_ms  = w_fsin[0];
    end else begin
      w_ms1 = r_S1[w_nbin];
      w_ms2 = r_S2[w_nbin];
      w_mc  = r_scos[w_nbin];
      w_ms  = r_ssin[w_nbin];
    end
    w_mre = PW'(w_mc) * PW'(w_ms2);
    w_mim = PW'(w_ms) * PW'(w_ms2);
    w_re  = PW'(w_ms1) - (w_mre >>> SH);
    w_im  = w_mim >>> SH;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      for (int b = 0; b < NBIN; b++) begin
        r_s1[b]   <= '0;
        r_s2[b]   <= '0;
        r_cos[b]  <= '0;
        r_sin[b]  <= '0;
        r_S1[b]   <= '0;
        r_S2[b]   <= '0;
        r_scos[b] <= '0;
        r_ssin[b] <= '0;
      end
    end else begin
      if (i_valid) begin
        r_cnt <= r_cnt + LGN'(1);
        for (int b = 0; b < NBIN; b++) begin
          r_s1[b]  <= w_snew[b];
          r_s2[b]  <= w_s1e[b];
          r_cos[b] <= w_fcos[b];
          r_sin[b] <= w_fsin[b];
        end
      end
      if (w_snap) begin
        for (int b = 0; b < NBIN; b++) begin
          r_S1[b]   <= w_snew[b];
          r_S2[b]   <= w_s1e[b];
          r_scos[b] <= w_fcos[b];
          r_ssin[b] <= w_fsin[b];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_bin     <= '0;
      o_re      <= '0;
      o_im      <= '0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= w_fend & ~w_snap;
      if (w_snap) begin
        o_valid <= 1'b1;
        o_busy  <= 1'b1;
        o_bin   <= '0;
        o_re    <= OW'(w_re);
        o_im    <= OW'(w_im);
      end else if (w_lastx) begin
        o_valid <= 1'b0;
        o_busy  <= 1'b0;
        o_bin   <= '0;
      end else if (w_xfer) begin
        o_bin <= w_nbin;
        o_re  <= OW'(w_re);
        o_im  <= OW'(w_im);
      end
    end
  end

endmodule

// File: tb/tb_goertzel_bank.sv
// tb_goertzel_bank: randomized and directed checks of goertzel_bank against
// a frame-level reference model.
module tb_goertzel_bank;
  localparam int SW   = 12;
  localparam int LGN  = 4;
  localparam int NBIN = 4;
  localparam int CFW  = 16;
  localparam int OW   = 32;
  localparam int N    = 1 << LGN;
  localparam int BW   = 2;
  localparam int SH   = CFW - 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 i_ready = 1'b0;
  logic signed [SW-1:0] i_sample = '0;
  logic [NBIN*CFW-1:0]  i_cos;
  logic [NBIN*CFW-1:0]  i_sin;
  logic                 o_valid;
  logic [BW-1:0]        o_bin;
  logic signed [OW-1:0] o_re;
  logic signed [OW-1:0] o_im;
  logic                 o_busy;
  logic                 o_overrun;

  int errors = 0;
  int checks = 0;

  int cos_a [NBIN];
  int sin_a [NBIN];
  int mc    [NBIN];
  int ms    [NBIN];
  int fx    [N];
  longint exp_re [NBIN];
  longint exp_im [NBIN];

  logic [BW-1:0]        q_bin [$];
  logic signed [OW-1:0] q_re  [$];
  logic signed [OW-1:0] q_im  [$];
  int ov_cnt = 0;

  goertzel_bank #(
    .SW(SW), .LGN(LGN), .NBIN(NBIN), .CFW(CFW), .OW(OW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid),
    .i_sample(i_sample), .i_cos(i_cos), .i_sin(i_sin),
    .o_valid(o_valid), .i_ready(i_ready), .o_bin(o_bin),
    .o_re(o_re), .o_im(o_im), .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_cos = '0;
    i_sin = '0;
    for (int b = 0; b < NBIN; b++) begin
      i_cos[b*CFW +: CFW] = cos_a[b][CFW-1:0];
      i_sin[b*CFW +: CFW] = sin_a[b][CFW-1:0];
    end
  end

  // Transfers are logged mid-cycle, before the edge that completes them
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      q_bin.push_back(o_bin);
      q_re.push_back(o_re);
      q_im.push_back(o_im);
    end
    if (o_overrun) ov_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic feed(input int x);
    i_sample = x[SW-1:0];
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic base_coefs();
    cos_a = '{16384, 0, 11585, -16384};
    sin_a = '{0, 16384, 11585, 0};
    mc = cos_a;
    ms = sin_a;
  endtask

  task automatic model_frame();
    longint s1, s2, sn;
    for (int b = 0; b < NBIN; b++) begin
      s1 = 0;
      s2 = 0;
      for (int n = 0; n < N; n++) begin
        sn = longint'(fx[n]) + ((2 * longint'(mc[b]) * s1) >>> SH) - s2;
        s2 = s1;
        s1 = sn;
      end
      exp_re[b] = s1 - ((longint'(mc[b]) * s2) >>> SH);
      exp_im[b] = (longint'(ms[b]) * s2) >>> SH;
    end
  endtask

  // mode 0: ready held high, 1: alternating, 2: random
  task automatic drain(input int mode, input int n, input int base,
                       output bit ok);
    for (int c = 0; c < 200; c++) begin
      if (q_re.size() - base >= n) break;
      case (mode)
        0: i_ready = 1'b1;
        1: i_ready = (c % 2 == 0);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
    end
    i_ready = 1'b0;
    ok = (q_re.size() - base >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_valid = 1'b1;
    i_sample = 12'sd5;
    repeat (2) tick();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b busy=%b ovr=%b, want 0 0 0",
               o_valid, o_busy, o_overrun);
    end
    checks++;
    if (o_bin !== '0 || o_re !== '0 || o_im !== '0) begin
      errors++;
      $display("FAIL reset_data: got bin=%0d re=%0d im=%0d, want 0 0 0",
               o_bin, o_re, o_im);
    end
    i_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_dc();
    int base;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) fx[n] = 100;
    model_frame();
    base = q_re.size();
    i_ready = 1'b1;
    for (int n = 0; n < N-1; n++) feed(100);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL dc_early: got o_valid=%b after 15 samples, want 0", o_valid);
    end
    feed(100);
    checks++;
    if (o_valid !== 1'b1 || o_bin !== '0 || o_re !== 32'sd1600 || o_im !== '0) begin
      errors++;
      $display("FAIL dc_latency: got v=%b bin=%0d re=%0d im=%0d, want 1 0 1600 0",
               o_valid, o_bin, o_re, o_im);
    end
    drain(0, NBIN, base, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dc_drain: got %0d results, want %0d", q_re.size() - base, NBIN);
    end
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (q_bin[base+i] !== BW'(i) || q_re[base+i] !== exp_re[i][OW-1:0]
          || q_im[base+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL dc_bin%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+i], q_re[base+i], q_im[base+i], i, exp_re[i], exp_im[i]);
      end
    end
    checks++;
    if (q_re[base] !== 32'sd1600 || q_re[base+1] !== '0 || q_im[base+1] !== '0) begin
      errors++;
      $display("FAIL dc_const: got b0re=%0d b1re=%0d b1im=%0d, want 1600 0 0",
               q_re[base], q_re[base+1], q_im[base+1]);
    end
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL dc_idle: got v=%b busy=%b, want 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) fx[n] = 100;
    model_frame();
    base = q_re.size();
    for (int n = 0; n < N; n++) feed(100);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_bin !== '0
          || o_re !== 32'sd1600 || o_im !== '0) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b busy=%b bin=%0d re=%0d im=%0d, want 1 1 0 1600 0",
                 c, o_valid, o_busy, o_bin, o_re, o_im);
      end
      tick();
    end
    drain(1, NBIN, base, ok);
    i_ready = 1'b1;
    repeat (3) tick();
    i_ready = 1'b0;
    checks++;
    if (!ok || q_re.size() - base != NBIN || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d results v=%b, want %0d v=0",
               q_re.size() - base, o_valid, NBIN);
    end
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (q_bin[base+i] !== BW'(i) || q_re[base+i] !== exp_re[i][OW-1:0]
          || q_im[base+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL bp_bin%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+i], q_re[base+i], q_im[base+i], i, exp_re[i], exp_im[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    int ov0;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) feed(100);
    ov0 = ov_cnt;
    for (int n = 0; n < N-1; n++) feed(int'($urandom_range(0, 4095)) - 2048);
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got o_overrun=%b before frame end, want 0", o_overrun);
    end
    feed(int'($urandom_range(0, 4095)) - 2048);
    checks++;
    if (o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got o_overrun=%b at frame end, want 1", o_overrun);
    end
    tick();
    checks++;
    if (o_overrun !== 1'b0 || ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL ovr_width: got ovr=%b pulses=%0d, want 0 and 1", o_overrun, ov_cnt - ov0);
    end
    checks++;
    if (o_valid !== 1'b1 || o_bin !== '0 || o_re !== 32'sd1600) begin
      errors++;
      $display("FAIL ovr_held: got v=%b bin=%0d re=%0d, want 1 0 1600", o_valid, o_bin, o_re);
    end
    for (int n = 0; n < N; n++) fx[n] = 100;
    model_frame();
    base = q_re.size();
    drain(0, NBIN, base, ok);
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (!ok || q_bin[base+i] !== BW'(i) || q_re[base+i] !== exp_re[i][OW-1:0]
          || q_im[base+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL ovr_old%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+i], q_re[base+i], q_im[base+i], i, exp_re[i], exp_im[i]);
      end
    end
    for (int n = 0; n < N; n++) fx[n] = int'($urandom_range(0, 4095)) - 2048;
    model_frame();
    base = q_re.size();
    i_ready = 1'b1;
    for (int n = 0; n < N; n++) feed(fx[n]);
    drain(0, NBIN, base, ok);
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (!ok || q_bin[base+i] !== BW'(i) || q_re[base+i] !== exp_re[i][OW-1:0]
          || q_im[base+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL ovr_third%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+i], q_re[base+i], q_im[base+i], i, exp_re[i], exp_im[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int f1 [N];
    int f2 [N];
    longint e1re [NBIN];
    longint e1im [NBIN];
    int base;
    int ov0;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) begin
      f1[n] = int'($urandom_range(0, 4095)) - 2048;
      f2[n] = int'($urandom_range(0, 4095)) - 2048;
    end
    fx = f1;
    model_frame();
    e1re = exp_re;
    e1im = exp_im;
    fx = f2;
    model_frame();
    base = q_re.size();
    ov0 = ov_cnt;
    for (int k = 0; k < 2*N; k++) begin
      i_ready = (k >= 2*N - NBIN);
      feed(k < N ? f1[k] : f2[k-N]);
    end
    checks++;
    if (o_overrun !== 1'b0 || o_valid !== 1'b1 || o_bin !== '0
        || o_re !== exp_re[0][OW-1:0] || o_im !== exp_im[0][OW-1:0]) begin
      errors++;
      $display("FAIL b2b_new: got ovr=%b v=%b bin=%0d re=%0d im=%0d, want 0 1 0 %0d %0d",
               o_overrun, o_valid, o_bin, o_re, o_im, exp_re[0], exp_im[0]);
    end
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (q_bin[base+i] !== BW'(i) || q_re[base+i] !== e1re[i][OW-1:0]
          || q_im[base+i] !== e1im[i][OW-1:0]) begin
        errors++;
        $display("FAIL b2b_f1_%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+i], q_re[base+i], q_im[base+i], i, e1re[i], e1im[i]);
      end
    end
    drain(0, 2*NBIN, base, ok);
    for (int i = 0; i < NBIN; i++) begin
      checks++;
      if (!ok || q_bin[base+NBIN+i] !== BW'(i) || q_re[base+NBIN+i] !== exp_re[i][OW-1:0]
          || q_im[base+NBIN+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL b2b_f2_%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                 i, q_bin[base+NBIN+i], q_re[base+NBIN+i], q_im[base+NBIN+i],
                 i, exp_re[i], exp_im[i]);
      end
    end
    checks++;
    if (ov_cnt != ov0) begin
      errors++;
      $display("FAIL b2b_ovr: got %0d overrun pulses, want 0", ov_cnt - ov0);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) feed(100);
    for (int n = 0; n < 7; n++) feed(int'($urandom_range(0, 4095)) - 2048);
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_overrun !== 1'b0
        || o_bin !== '0 || o_re !== '0 || o_im !== '0) begin
      errors++;
      $display("FAIL rmid_async: got v=%b busy=%b ovr=%b bin=%0d re=%0d im=%0d, want all 0",
               o_valid, o_busy, o_overrun, o_bin, o_re, o_im);
    end
    i_valid = 1'b1;
    i_sample = 12'sd100;
    repeat (2) tick();
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_re !== '0 || o_im !== '0) begin
      errors++;
      $display("FAIL rmid_hold: got v=%b busy=%b re=%0d im=%0d, want all 0",
               o_valid, o_busy, o_re, o_im);
    end
    i_valid = 1'b0;
    rst = 1'b0;
    tick();
    base = q_re.size();
    i_ready = 1'b1;
    for (int n = 0; n < N-1; n++) feed(100);
    checks++;
    if (o_valid !== 1'b0 || q_re.size() != base) begin
      errors++;
      $display("FAIL rmid_early: got v=%b results=%0d after 15 samples, want 0 0",
               o_valid, q_re.size() - base);
    end
    feed(100);
    checks++;
    if (o_valid !== 1'b1 || o_bin !== '0 || o_re !== 32'sd1600) begin
      errors++;
      $display("FAIL rmid_first: got v=%b bin=%0d re=%0d, want 1 0 1600", o_valid, o_bin, o_re);
    end
    drain(0, NBIN, base, ok);
  endtask

  task automatic test_coef_latch();
    int base;
    bit ok;
    do_reset();
    base_coefs();
    for (int n = 0; n < N; n++) fx[n] = 100;
    model_frame();
    base = q_re.size();
    i_ready = 1'b1;
    for (int n = 0; n < N; n++) begin
      if (n == 5) begin
        cos_a[0] = 0;
        cos_a[2] = -7000;
        sin_a[1] = 5;
      end
      feed(100);
    end
    drain(0, NBIN, base, ok);
    checks++;
    if (!ok || q_re[base] !== 32'sd1600 || q_im[base] !== '0) begin
      errors++;
      $display("FAIL latch_b0: got re=%0d im=%0d, want 1600 0", q_re[base], q_im[base]);
    end
    for (int i = 1; i < NBIN; i++) begin
      checks++;
      if (!ok || q_re[base+i] !== exp_re[i][OW-1:0] || q_im[base+i] !== exp_im[i][OW-1:0]) begin
        errors++;
        $display("FAIL latch_b%0d: got re=%0d im=%0d, want %0d %0d",
                 i, q_re[base+i], q_im[base+i], exp_re[i], exp_im[i]);
      end
    end
    base_coefs();
  endtask

  task automatic test_random();
    int base;
    int n;
    int scr;
    bit ok;
    do_reset();
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < NBIN; b++) begin
        cos_a[b] = int'($urandom_range(0, 32768)) - 16384;
        sin_a[b] = int'($urandom_range(0, 32768)) - 16384;
      end
      mc = cos_a;
      ms = sin_a;
      for (int k = 0; k < N; k++) fx[k] = int'($urandom_range(0, 4095)) - 2048;
      model_frame();
      scr = int'($urandom_range(1, N-1));
      base = q_re.size();
      n = 0;
      for (int c = 0; c < 200 && n < N; c++) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_sample = fx[n][SW-1:0];
        i_ready = 1'($urandom_range(0, 1));
        if (i_valid && n == scr) begin
          for (int b = 0; b < NBIN; b++) begin
            cos_a[b] = int'($urandom_range(0, 32768)) - 16384;
            sin_a[b] = int'($urandom_range(0, 32768)) - 16384;
          end
        end
        tick();
        if (i_valid) n++;
      end
      i_valid = 1'b0;
      drain(2, NBIN, base, ok);
      for (int i = 0; i < NBIN; i++) begin
        checks++;
        if (!ok || q_bin[base+i] !== BW'(i) || q_re[base+i] !== exp_re[i][OW-1:0]
            || q_im[base+i] !== exp_im[i][OW-1:0]) begin
          errors++;
          $display("FAIL rand_f%0d_b%0d: got bin=%0d re=%0d im=%0d, want bin=%0d re=%0d im=%0d",
                   f, i, q_bin[base+i], q_re[base+i], q_im[base+i], i, exp_re[i], exp_im[i]);
        end
      end
    end
  endtask

  initial begin
    base_coefs();
    test_reset();
    test_dc();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_coef_latch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
